// File: rtl/rs232_rx_fifo_pkg.sv
// ============================================================================
// rs232_rx_fifo_pkg : shared RS-232 constants, FSM encoding and vote helper. Rev 1.0
// ============================================================================
`default_nettype none

package rs232_rx_fifo_pkg;

   localparam int C_RS232_DIV = 54;

   // Subcounts whose samples form the mid-bit majority vote
   localparam logic [3:0] C_VOTE_SUB_A = 4'd7;
   localparam logic [3:0] C_VOTE_SUB_B = 4'd8;
   localparam logic [3:0] C_VOTE_SUB_C = 4'd9;

   typedef enum logic [2:0] {
      ST_WAITHI = 3'd0,
      ST_IDLE   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rs232_rx_fifo_if.sv
// ============================================================================
// rs232_rx_fifo_if : read-side and error-flag bundle of the buffered receiver. Rev 1.0
// ============================================================================
`default_nettype none

interface rs232_rx_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  rd_en;
   logic [7:0]            rd_data;
   logic                  rd_valid;
   logic [DEPTH_LOG2:0]   count;
   logic                  frame_err;
   logic                  overrun;
   logic                  clr_err;

   modport master (
      output rd_en, clr_err,
      input  rd_data, rd_valid, count, frame_err, overrun
   );

   modport slave (
      input  rd_en, clr_err,
      output rd_data, rd_valid, count, frame_err, overrun
   );
endinterface

`default_nettype wire

// File: rtl/rs232_rx_fifo_sync_fifo.sv
// ============================================================================
// rs232_rx_fifo_sync_fifo : first-word-fall-through FIFO with wrap pointers. Rev 1.0
// ============================================================================
`default_nettype none

module rs232_rx_fifo_sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  wire logic                  clock,
   input  wire logic                  reset,
   input  wire logic                  wr_en,
   input  wire logic [WIDTH-1:0]      wr_data,
   output logic                       full,
   input  wire logic                  rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   output logic [DEPTH_LOG2:0]        count
);
   localparam int C_DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      r_mem [C_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  w_push;
   logic                  w_pop;

   assign rd_valid = (r_count != '0);
   assign full     = (r_count == (DEPTH_LOG2+1)'(C_DEPTH));
   assign w_pop    = rd_en & rd_valid;
   // A full FIFO still accepts a write when the head leaves in the same cycle
   assign w_push   = wr_en & (~full | w_pop);
   assign rd_data  = rd_valid ? r_mem[r_rd_ptr] : '0;
   assign count    = r_count;

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/rs232_rx_fifo.sv
// ============================================================================
// rs232_rx_fifo : 16x-oversampled 8N1 receiver feeding a receive FIFO, with error flags. Rev 1.0
// ============================================================================
`default_nettype none

module rs232_rx_fifo
   import rs232_rx_fifo_pkg::*;
#(
   parameter int DIV        = C_RS232_DIV,
   parameter int DEPTH_LOG2 = 4
) (
   input  wire logic       clock,
   input  wire logic       reset,
   input  wire logic       RxD,
   rs232_rx_fifo_if.slave  rd
);
   localparam int C_TW = (DIV > 1) ? $clog2(DIV) : 1;

   logic            r_rx_meta;
   logic            r_rxs;
   logic [C_TW-1:0] r_tick_cnt;
   logic [3:0]      r_sub;
   logic            r_samp_a;
   logic            r_samp_b;
   logic            r_hi_run;
   logic [7:0]      r_shreg;
   logic [2:0]      r_bit_idx;
   logic            r_frame_err;
   logic            r_overrun;
   rx_state_t       r_state;
   rx_state_t       w_state_next;

   logic w_tick;
   logic w_start;
   logic w_decide;
   logic w_vote;
   logic w_push;
   logic w_frame_set;
   logic w_shift_en;
   logic w_full;
   logic w_overrun_set;

   assign w_tick   = (r_tick_cnt == C_TW'(DIV - 1));
   assign w_start  = (r_state == ST_IDLE) && !r_rxs;
   assign w_decide = w_tick && (r_sub == C_VOTE_SUB_C);
   assign w_vote   = majority3(r_samp_a, r_samp_b, r_rxs);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
      end else begin
         r_rx_meta <= RxD;
         r_rxs     <= r_rx_meta;
      end
   end

   // Counters restart on the start edge so every vote lands at a fixed bit phase
   always_ff @(posedge clock) begin
      if (reset || w_start) begin
         r_tick_cnt <= '0;
         r_sub      <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
         r_sub      <= r_sub + 4'd1;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_samp_a  <= 1'b1;
         r_samp_b  <= 1'b1;
         r_hi_run  <= 1'b0;
         r_shreg   <= '0;
         r_bit_idx <= '0;
      end else begin
         if (w_tick && r_sub == C_VOTE_SUB_A) r_samp_a <= r_rxs;
         if (w_tick && r_sub == C_VOTE_SUB_B) r_samp_b <= r_rxs;
         // Tracks whether the line stayed high for the whole current tick window
         if (w_tick)      r_hi_run <= 1'b1;
         else if (!r_rxs) r_hi_run <= 1'b0;
         if (w_shift_en)  r_shreg <= {w_vote, r_shreg[7:1]};
         if (r_state != ST_DATA) r_bit_idx <= '0;
         else if (w_shift_en)    r_bit_idx <= r_bit_idx + 3'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_WAITHI;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_push       = 1'b0;
      w_frame_set  = 1'b0;
      w_shift_en   = 1'b0;
      case (r_state)
         ST_WAITHI: if (w_tick && r_hi_run && r_rxs) w_state_next = ST_IDLE;
         ST_IDLE:   if (!r_rxs) w_state_next = ST_START;
         ST_START:  if (w_decide) w_state_next = w_vote ? ST_IDLE : ST_DATA;
         ST_DATA: begin
            if (w_decide) begin
               w_shift_en = 1'b1;
               if (r_bit_idx == 3'd7) w_state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_decide) begin
               if (w_vote) begin
                  w_push       = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_frame_set  = 1'b1;
                  w_state_next = ST_WAITHI;
               end
            end
         end
         default: w_state_next = ST_WAITHI;
      endcase
   end

   assign w_overrun_set = w_push & w_full & ~rd.rd_en;

   // A new error event outranks a simultaneous clear
   always_ff @(posedge clock) begin
      if (reset) begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_frame_set)     r_frame_err <= 1'b1;
         else if (rd.clr_err) r_frame_err <= 1'b0;
         if (w_overrun_set)   r_overrun <= 1'b1;
         else if (rd.clr_err) r_overrun <= 1'b0;
      end
   end

   assign rd.frame_err = r_frame_err;
   assign rd.overrun   = r_overrun;

   rs232_rx_fifo_sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (w_push),
      .wr_data  (r_shreg),
      .full     (w_full),
      .rd_en    (rd.rd_en),
      .rd_data  (rd.rd_data),
      .rd_valid (rd.rd_valid),
      .count    (rd.count)
   );

endmodule

`default_nettype wire
